// File: rtl/if_fetch_unit_if.sv
// Fetch-side bus: instruction memory request/response and branch predictor lookup.
// The fetch unit is the master; memory and predictor sit behind the slave modport.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] bpu_lookup_pc;
  logic        bpu_hit;
  logic [31:0] bpu_target;
  logic [4:0]  bpu_index;

  modport master (
    output imem_req,
    output imem_addr,
    output bpu_lookup_pc,
    input  imem_ack,
    input  imem_rdata,
    input  bpu_hit,
    input  bpu_target,
    input  bpu_index
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  bpu_lookup_pc,
    output imem_ack,
    output imem_rdata,
    output bpu_hit,
    output bpu_target,
    output bpu_index
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, branch-predicted next PC,
// and a two-entry fetch queue feeding the IF/ID stage.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pa_pc_ifid,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  if_fetch_unit_if.master       bus,
  output logic [31:0]           if_pc_out,
  output logic [31:0]           if_pc_4_out,
  output logic [31:0]           if_instr_out,
  output logic [31:0]           if_bpu_pc,
  output logic [4:0]            if_bpu_index
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] bpu_pc;
    logic [4:0]  bpu_index;
  } entry_t;

  localparam entry_t EMPTY = {32'd0, 32'd0, 32'd0, 5'd0};
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] tag_next_pc;
  logic [4:0]  tag_index;
  entry_t      q0;
  entry_t      q1;
  logic [1:0]  count;

  logic        pop;
  logic        room;
  logic        issue;
  logic        accept;
  logic        req;
  logic [31:0] fetch_addr;
  logic [31:0] pred_pc;
  logic [31:0] redir_pc;
  entry_t      new_entry;
  entry_t      q0_next;
  entry_t      q1_next;
  logic [1:0]  count_next;
  logic        head_valid;

  // Request/issue decode; DISCARD keeps presenting the abandoned address until acked.
  always_comb begin
    pop        = !pa_pc_ifid && (count != 2'd0);
    room       = (count - {1'b0, pop}) < 2'd2;
    fetch_addr = (state == S_RUN) ? (pc & ALIGN_MASK) : (req_pc & ALIGN_MASK);
    redir_pc   = redirect_pc & ALIGN_MASK;
    pred_pc    = bus.bpu_hit ? (bus.bpu_target & ALIGN_MASK) : (pc + 32'd4);
    issue      = !reset && (state == S_RUN) && room && !redirect_valid;
    if (reset) begin
      req = 1'b0;
    end else if (state == S_RUN) begin
      req = room && !redirect_valid;
    end else begin
      req = 1'b1;
    end
    accept = !reset && !redirect_valid && bus.imem_ack && (issue || (state == S_WAIT));
  end

  assign bus.imem_req      = req;
  assign bus.imem_addr     = fetch_addr;
  assign bus.bpu_lookup_pc = fetch_addr;

  // Entry built from the response; zero-wait responses use the live prediction.
  always_comb begin
    new_entry.pc    = fetch_addr;
    new_entry.instr = bus.imem_rdata;
    if (state == S_RUN) begin
      new_entry.bpu_pc    = pred_pc;
      new_entry.bpu_index = bus.bpu_index;
    end else begin
      new_entry.bpu_pc    = tag_next_pc;
      new_entry.bpu_index = tag_index;
    end
  end

  // Fetch FSM, PC and request tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      req_pc      <= 32'd0;
      tag_next_pc <= 32'd0;
      tag_index   <= 5'd0;
    end else begin
      case (state)
        S_RUN: begin
          if (redirect_valid) begin
            pc <= redir_pc;
          end else if (issue) begin
            req_pc      <= pc;
            tag_next_pc <= pred_pc;
            tag_index   <= bus.bpu_index;
            if (bus.imem_ack) begin
              pc <= pred_pc;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc    <= redir_pc;
            state <= bus.imem_ack ? S_RUN : S_DISCARD;
          end else if (bus.imem_ack) begin
            pc    <= tag_next_pc;
            state <= S_RUN;
          end
        end
        S_DISCARD: begin
          if (redirect_valid) begin
            pc <= redir_pc;
          end
          if (bus.imem_ack) begin
            state <= S_RUN;
          end
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

  // Queue next state; slot q0 is always the head, vacated slots are zeroed.
  always_comb begin
    q0_next    = q0;
    q1_next    = q1;
    count_next = count;
    if (redirect_valid) begin
      q0_next    = EMPTY;
      q1_next    = EMPTY;
      count_next = 2'd0;
    end else begin
      case ({accept, pop})
        2'b11: begin
          if (count == 2'd1) begin
            q0_next = new_entry;
          end else begin
            q0_next = q1;
            q1_next = new_entry;
          end
        end
        2'b10: begin
          if (count == 2'd0) begin
            q0_next = new_entry;
          end else begin
            q1_next = new_entry;
          end
          count_next = count + 2'd1;
        end
        2'b01: begin
          q0_next    = q1;
          q1_next    = EMPTY;
          count_next = count - 2'd1;
        end
        default: begin
          count_next = count;
        end
      endcase
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      q0    <= EMPTY;
      q1    <= EMPTY;
      count <= 2'd0;
    end else begin
      q0    <= q0_next;
      q1    <= q1_next;
      count <= count_next;
    end
  end

  // Head presentation; an empty queue reads as an all-zero bubble.
  always_comb begin
    head_valid = (count != 2'd0) && !reset;
    if (head_valid) begin
      if_pc_out    = q0.pc;
      if_pc_4_out  = q0.pc + 32'd4;
      if_instr_out = q0.instr;
      if_bpu_pc    = q0.bpu_pc;
      if_bpu_index = q0.bpu_index;
    end else begin
      if_pc_out    = 32'd0;
      if_pc_4_out  = 32'd0;
      if_instr_out = 32'd0;
      if_bpu_pc    = 32'd0;
      if_bpu_index = 5'd0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory/predictor environment, reference model with a
// scoreboard of expected queue entries, a vector table and multi-cycle sequences.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] KEY      = 32'h5A5A_0F0F;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] bpu_pc;
    logic [4:0]  idx;
  } exp_t;

  typedef struct {
    logic        pa;
    logic        req;
    logic [31:0] addr;
    logic [31:0] head;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pa_pc_ifid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc_out, if_pc_4_out, if_instr_out, if_bpu_pc;
  logic [4:0]  if_bpu_index;

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .pa_pc_ifid    (pa_pc_ifid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .bus           (bus),
    .if_pc_out     (if_pc_out),
    .if_pc_4_out   (if_pc_4_out),
    .if_instr_out  (if_instr_out),
    .if_bpu_pc     (if_bpu_pc),
    .if_bpu_index  (if_bpu_index)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  int          lat   = 0;
  int          wcnt  = 0;
  logic [31:0] hit_pc  = 32'h0000_0001;
  logic [31:0] hit_tgt = 32'd0;
  logic [31:0] model_pc = RESET_PC;
  logic        disc = 1'b0;
  logic [31:0] disc_addr = 32'd0;
  exp_t        sb[$];
  logic        obs_req;
  logic [31:0] obs_addr, obs_pc, obs_pc4;
  vec_t        vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, respond as memory/predictor, check at negedge, update model.
  task automatic cyc(input logic pa_i, input logic rv_i, input logic [31:0] rpc_i,
                     input logic rst_i, input logic fack_i);
    logic        pop_m, req_m, gack;
    logic [31:0] nxt;
    int          sz;
    reset          = rst_i;
    pa_pc_ifid     = pa_i;
    redirect_valid = rv_i;
    redirect_pc    = rpc_i;
    #1;
    gack             = bus.imem_req && (wcnt >= lat);
    bus.imem_ack     = gack || fack_i;
    bus.imem_rdata   = fack_i ? 32'hDEAD_BEEF : (bus.imem_addr ^ KEY);
    bus.bpu_hit      = (bus.bpu_lookup_pc == hit_pc);
    bus.bpu_target   = hit_tgt;
    bus.bpu_index    = bus.bpu_lookup_pc[6:2];
    @(negedge clk);
    obs_req  = bus.imem_req;
    obs_addr = bus.imem_addr;
    obs_pc   = if_pc_out;
    obs_pc4  = if_pc_4_out;
    sz       = sb.size();
    pop_m    = !pa_i && (sz > 0);
    if (rst_i) req_m = 1'b0;
    else if (wcnt != 0) req_m = 1'b1;
    else req_m = !rv_i && ((sz - int'(pop_m)) < 2);
    if (rst_i) begin
      chk("rst_req", {31'd0, obs_req}, 32'd0);
      chk("rst_pc", obs_pc, 32'd0);
      chk("rst_pc4", obs_pc4, 32'd0);
      chk("rst_instr", if_instr_out, 32'd0);
    end else begin
      chk("req", {31'd0, obs_req}, {31'd0, req_m});
      chk("addr", obs_addr, disc ? disc_addr : model_pc);
      chk("lookup", bus.bpu_lookup_pc, disc ? disc_addr : model_pc);
      if (sz == 0) begin
        chk("bubble_pc", obs_pc, 32'd0);
        chk("bubble_pc4", obs_pc4, 32'd0);
        chk("bubble_instr", if_instr_out, 32'd0);
        chk("bubble_bpu", if_bpu_pc, 32'd0);
        chk("bubble_idx", {27'd0, if_bpu_index}, 32'd0);
      end else begin
        chk("head_pc", obs_pc, sb[0].pc);
        chk("head_pc4", obs_pc4, sb[0].pc + 32'd4);
        chk("head_instr", if_instr_out, sb[0].instr);
        chk("head_bpu", if_bpu_pc, sb[0].bpu_pc);
        chk("head_idx", {27'd0, if_bpu_index}, {27'd0, sb[0].idx});
      end
    end
    @(posedge clk);
    if (rst_i) begin
      sb.delete();
      model_pc = RESET_PC;
      disc     = 1'b0;
      wcnt     = 0;
    end else begin
      if (obs_req && !gack) wcnt++;
      else wcnt = 0;
      if (rv_i) begin
        sb.delete();
        if (req_m && !gack) begin
          if (!disc) disc_addr = model_pc;
          disc = 1'b1;
        end else begin
          disc = 1'b0;
        end
        model_pc = rpc_i & 32'hFFFF_FFFC;
      end else begin
        if (pop_m) void'(sb.pop_front());
        if (gack) begin
          if (disc) begin
            disc = 1'b0;
          end else begin
            nxt = (model_pc == hit_pc) ? hit_tgt : (model_pc + 32'd4);
            sb.push_back({model_pc, model_pc ^ KEY, nxt, model_pc[6:2]});
            model_pc = nxt;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic run(input int n, input logic pa_i);
    for (int i = 0; i < n; i++) cyc(pa_i, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; pa_pc_ifid = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.bpu_hit = 1'b0;
    bus.bpu_target = 32'd0; bus.bpu_index = 5'd0;

    // Zero-wait streaming, then a five-cycle stall and release.
    vt[0]  = '{1'b0, 1'b1, 32'hBFC0_0000, 32'h0000_0000};
    vt[1]  = '{1'b0, 1'b1, 32'hBFC0_0004, 32'hBFC0_0000};
    vt[2]  = '{1'b0, 1'b1, 32'hBFC0_0008, 32'hBFC0_0004};
    vt[3]  = '{1'b1, 1'b1, 32'hBFC0_000C, 32'hBFC0_0008};
    vt[4]  = '{1'b1, 1'b0, 32'hBFC0_0010, 32'hBFC0_0008};
    vt[5]  = '{1'b1, 1'b0, 32'hBFC0_0010, 32'hBFC0_0008};
    vt[6]  = '{1'b1, 1'b0, 32'hBFC0_0010, 32'hBFC0_0008};
    vt[7]  = '{1'b1, 1'b0, 32'hBFC0_0010, 32'hBFC0_0008};
    vt[8]  = '{1'b0, 1'b1, 32'hBFC0_0010, 32'hBFC0_0008};
    vt[9]  = '{1'b0, 1'b1, 32'hBFC0_0014, 32'hBFC0_000C};
    vt[10] = '{1'b0, 1'b1, 32'hBFC0_0018, 32'hBFC0_0010};

    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].pa, 1'b0, 32'd0, 1'b0, 1'b0);
      chk("tbl_req", {31'd0, obs_req}, {31'd0, vt[i].req});
      chk("tbl_addr", obs_addr, vt[i].addr);
      chk("tbl_head", obs_pc, vt[i].head);
    end
    run(3, 1'b0);

    // Predictor hit redirects the fetch stream.
    do_reset();
    hit_pc = 32'hBFC0_0004; hit_tgt = 32'h8000_1000;
    run(2, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("bpu_next_addr", obs_addr, 32'h8000_1000);
    run(3, 1'b0);
    hit_pc = 32'h0000_0001;

    // Redirect while waiting, then again while discarding (unaligned target).
    do_reset();
    lat = 3;
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0040_0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0040_0003, 1'b0, 1'b0);
    chk("discard_addr", obs_addr, 32'hBFC0_0000);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("discard_ack_addr", obs_addr, 32'hBFC0_0000);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("after_discard_addr", obs_addr, 32'h0040_0000);
    chk("after_discard_head", obs_pc, 32'd0);
    run(10, 1'b0);

    // Redirect coinciding with the ack while one entry is queued.
    do_reset();
    lat = 1;
    run(3, 1'b1);
    cyc(1'b1, 1'b1, 32'h0040_0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("flush_pc", obs_pc, 32'd0);
    chk("flush_pc4", obs_pc4, 32'd0);
    chk("flush_addr", obs_addr, 32'h0040_0000);
    run(4, 1'b0);

    // Stray ack with no request while the queue is full.
    do_reset();
    lat = 0;
    run(2, 1'b1);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    run(4, 1'b0);

    // PC wrap at the top of the address space, then reset during a wait.
    do_reset();
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    run(4, 1'b0);
    lat = 3;
    run(2, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("post_reset_addr", obs_addr, 32'hBFC0_0000);
    chk("post_reset_head", obs_pc, 32'd0);
    run(10, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
